// File: rtl/cv32e40p_x_copro_resp.sv
// CORE-V-XIF coprocessor responder: accepts custom-0 ALU instructions, queues them with operands,
// executes committed heads with fixed latency and returns results. Commit gating: X_COPRO_COMMIT_EN.
module cv32e40p_x_copro_resp #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LAT   = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             x_issue_valid_i,
   output logic             x_issue_ready_o,
   input  logic [31:0]      x_issue_req_instr_i,
   input  logic [3:0]       x_issue_req_id_i,
   input  logic [1:0][31:0] x_issue_req_rs_i,
   input  logic [2:0]       x_issue_req_rs_valid_i,
   output logic             x_issue_resp_accept_o,
   output logic             x_issue_resp_writeback_o,
   output logic             x_issue_resp_loadstore_o,
   input  logic             x_commit_valid_i,
   input  logic [3:0]       x_commit_id_i,
   input  logic             x_commit_kill_i,
   output logic             x_result_valid_o,
   input  logic             x_result_ready_i,
   output logic [3:0]       x_result_id_o,
   output logic [31:0]      x_result_data_o,
   output logic [4:0]       x_result_rd_o,
   output logic             x_result_we_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LAT_W = (LAT > 1) ? $clog2(LAT) : 1;
   localparam logic [6:0]  OPC_CUSTOM0 = 7'b0001011;

   typedef struct packed {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [1:0]  op;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic        committed;
      logic        killed;
   } entry_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESULT
   } state_e;

   entry_t           ent_q [DEPTH];
   entry_t           ent_d [DEPTH];
   logic [DEPTH-1:0] vld_q, vld_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_e           state_q, state_d;
   logic [LAT_W-1:0] cnt_q, cnt_d;

   logic             res_valid_q, res_valid_d;
   logic [3:0]       res_id_q, res_id_d;
   logic [31:0]      res_data_q, res_data_d;
   logic [4:0]       res_rd_q, res_rd_d;
   logic             res_we_q, res_we_d;

   logic [6:0]       opcode_c;
   logic [6:0]       funct7_c;
   logic [2:0]       funct3_c;
   logic [4:0]       rd_c;
   logic             accept_c;
   logic             full_c;
   logic             rs_ok_c;
   logic             ready_c;
   logic             push_c;
   logic             pop_c;
   entry_t           push_entry_c;
   entry_t           head_c;
   logic             unused_c;

   function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
      logic [31:0] r;
      unique case (op)
         2'd0:    r = a + b;
         2'd1:    r = a - b;
         2'd2:    r = a * b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   // Combinational decode and issue response
   assign opcode_c = x_issue_req_instr_i[6:0];
   assign funct3_c = x_issue_req_instr_i[14:12];
   assign funct7_c = x_issue_req_instr_i[31:25];
   assign rd_c     = x_issue_req_instr_i[11:7];
   assign accept_c = (opcode_c == OPC_CUSTOM0) && (funct7_c == 7'd0) && !funct3_c[2];

   // Full is taken from the registered count only, so a same-cycle pop does not free a slot
   assign full_c  = (count_q == CNT_W'(DEPTH));
   assign rs_ok_c = x_issue_req_rs_valid_i[0] & x_issue_req_rs_valid_i[1];
   assign ready_c = ~full_c & (~accept_c | rs_ok_c);
   assign push_c  = x_issue_valid_i & ready_c & accept_c;

   assign x_issue_ready_o          = ready_c;
   assign x_issue_resp_accept_o    = accept_c;
   assign x_issue_resp_writeback_o = accept_c & (rd_c != 5'd0);
   assign x_issue_resp_loadstore_o = 1'b0;

   always_comb begin
      push_entry_c.id        = x_issue_req_id_i;
      push_entry_c.rd        = rd_c;
      push_entry_c.op        = funct3_c[1:0];
      push_entry_c.rs1       = x_issue_req_rs_i[0];
      push_entry_c.rs2       = x_issue_req_rs_i[1];
`ifdef X_COPRO_COMMIT_EN
      push_entry_c.committed = 1'b0;
`else
      push_entry_c.committed = 1'b1;
`endif
      push_entry_c.killed    = 1'b0;
   end

`ifdef X_COPRO_COMMIT_EN
   assign unused_c = ^{x_issue_req_instr_i[24:15], x_issue_req_rs_valid_i[2]};
`else
   assign unused_c = ^{x_issue_req_instr_i[24:15], x_issue_req_rs_valid_i[2],
                       x_commit_valid_i, x_commit_id_i, x_commit_kill_i};
`endif

   assign head_c = ent_q[rd_ptr_q];

   // Next-state: execution FSM, queue pointers and commit/kill marking
   always_comb begin
      ent_d       = ent_q;
      vld_d       = vld_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      cnt_d       = cnt_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_we_d    = res_we_q;
      pop_c       = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (vld_q[rd_ptr_q]) begin
               if (head_c.killed) begin
                  pop_c = 1'b1;
               end else if (head_c.committed) begin
                  state_d = S_EXEC;
                  cnt_d   = '0;
               end
            end
         end
         S_EXEC: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAT_W'(LAT - 1)) begin
               res_valid_d = 1'b1;
               res_id_d    = head_c.id;
               res_data_d  = alu(head_c.op, head_c.rs1, head_c.rs2);
               res_rd_d    = head_c.rd;
               res_we_d    = (head_c.rd != 5'd0);
               state_d     = S_RESULT;
            end
         end
         S_RESULT: begin
            if (x_result_ready_i) begin
               pop_c       = 1'b1;
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (pop_c) begin
         vld_d[rd_ptr_q] = 1'b0;
         rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (push_c) begin
         ent_d[wr_ptr_q] = push_entry_c;
         vld_d[wr_ptr_q] = 1'b1;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

`ifdef X_COPRO_COMMIT_EN
      // Matching after the push lets a same-cycle commit land on the newly issued entry
      if (x_commit_valid_i) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            if (vld_d[i] && (ent_d[i].id == x_commit_id_i) &&
                !ent_d[i].committed && !ent_d[i].killed) begin
               if (x_commit_kill_i) ent_d[i].killed    = 1'b1;
               else                 ent_d[i].committed = 1'b1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ent_q       <= '{default: '0};
         vld_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         res_we_q    <= 1'b0;
      end else begin
         ent_q       <= ent_d;
         vld_q       <= vld_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_we_q    <= res_we_d;
      end
   end

   assign x_result_valid_o = res_valid_q;
   assign x_result_id_o    = res_id_q;
   assign x_result_data_o  = res_data_q;
   assign x_result_rd_o    = res_rd_q;
   assign x_result_we_o    = res_we_q;

endmodule

// File: tb/tb_cv32e40p_x_copro_resp.sv
// Bench for cv32e40p_x_copro_resp: directed and random offers/commits checked each cycle
// against a queue-based reference model. Follows X_COPRO_COMMIT_EN like the design.
module tb_cv32e40p_x_copro_resp;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned LAT   = 3;
`ifdef X_COPRO_COMMIT_EN
   localparam bit COMMIT_EN = 1'b1;
`else
   localparam bit COMMIT_EN = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             x_issue_valid_i;
   logic             x_issue_ready_o;
   logic [31:0]      x_issue_req_instr_i;
   logic [3:0]       x_issue_req_id_i;
   logic [1:0][31:0] x_issue_req_rs_i;
   logic [2:0]       x_issue_req_rs_valid_i;
   logic             x_issue_resp_accept_o;
   logic             x_issue_resp_writeback_o;
   logic             x_issue_resp_loadstore_o;
   logic             x_commit_valid_i;
   logic [3:0]       x_commit_id_i;
   logic             x_commit_kill_i;
   logic             x_result_valid_o;
   logic             x_result_ready_i;
   logic [3:0]       x_result_id_o;
   logic [31:0]      x_result_data_o;
   logic [4:0]       x_result_rd_o;
   logic             x_result_we_o;

   always #5 clk_i = ~clk_i;

   cv32e40p_x_copro_resp #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .clk_i                    (clk_i),
      .rst_i                    (rst_i),
      .x_issue_valid_i          (x_issue_valid_i),
      .x_issue_ready_o          (x_issue_ready_o),
      .x_issue_req_instr_i      (x_issue_req_instr_i),
      .x_issue_req_id_i         (x_issue_req_id_i),
      .x_issue_req_rs_i         (x_issue_req_rs_i),
      .x_issue_req_rs_valid_i   (x_issue_req_rs_valid_i),
      .x_issue_resp_accept_o    (x_issue_resp_accept_o),
      .x_issue_resp_writeback_o (x_issue_resp_writeback_o),
      .x_issue_resp_loadstore_o (x_issue_resp_loadstore_o),
      .x_commit_valid_i         (x_commit_valid_i),
      .x_commit_id_i            (x_commit_id_i),
      .x_commit_kill_i          (x_commit_kill_i),
      .x_result_valid_o         (x_result_valid_o),
      .x_result_ready_i         (x_result_ready_i),
      .x_result_id_o            (x_result_id_o),
      .x_result_data_o          (x_result_data_o),
      .x_result_rd_o            (x_result_rd_o),
      .x_result_we_o            (x_result_we_o)
   );

   typedef struct {
      logic [3:0]  id;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      bit          committed;
      bit          killed;
   } m_ent_t;

   m_ent_t      mq[$];
   bit          m_busy;
   int          m_wait;
   logic        m_rv;
   logic [3:0]  m_rid;
   logic [31:0] m_rdata;
   logic [4:0]  m_rrd;
   logic        m_rwe;
   int          n_vec = 0;
   int          n_err = 0;

   function automatic bit m_accept(input logic [31:0] ins);
      return (ins[6:0] == 7'b0001011) && (ins[31:25] == 7'd0) && (ins[14:12] <= 3'd3);
   endfunction

   function automatic logic [31:0] m_alu(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b);
      logic [63:0] p;
      p = 64'(a) * 64'(b);
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return p[31:0];
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [31:0] enc(input logic [6:0] opc, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {7'd0, 10'd0, f3, rd, opc};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_busy  = 1'b0;
      m_wait  = 0;
      m_rv    = 1'b0;
      m_rid   = '0;
      m_rdata = '0;
      m_rrd   = '0;
      m_rwe   = 1'b0;
   endtask

   // Reference: advance one clock edge given the inputs presented in this cycle
   task automatic model_step(input bit rdy);
      bit     pop;
      m_ent_t e;
      pop = 1'b0;
      if (m_rv) begin
         if (x_result_ready_i) begin
            pop  = 1'b1;
            m_rv = 1'b0;
         end
      end else if (m_busy) begin
         m_wait--;
         if (m_wait == 0) begin
            m_busy  = 1'b0;
            m_rv    = 1'b1;
            m_rid   = mq[0].id;
            m_rdata = m_alu(mq[0].f3, mq[0].a, mq[0].b);
            m_rrd   = mq[0].rd;
            m_rwe   = (mq[0].rd != 5'd0);
         end
      end else if (mq.size() > 0) begin
         if (mq[0].killed) pop = 1'b1;
         else if (mq[0].committed) begin
            m_busy = 1'b1;
            m_wait = LAT;
         end
      end
      if (pop) void'(mq.pop_front());
      if (x_issue_valid_i && rdy && m_accept(x_issue_req_instr_i)) begin
         e.id        = x_issue_req_id_i;
         e.rd        = x_issue_req_instr_i[11:7];
         e.f3        = x_issue_req_instr_i[14:12];
         e.a         = x_issue_req_rs_i[0];
         e.b         = x_issue_req_rs_i[1];
         e.committed = !COMMIT_EN;
         e.killed    = 1'b0;
         mq.push_back(e);
      end
      if (COMMIT_EN && x_commit_valid_i) begin
         foreach (mq[i]) begin
            if (mq[i].id == x_commit_id_i && !mq[i].committed && !mq[i].killed) begin
               if (x_commit_kill_i) mq[i].killed = 1'b1;
               else                 mq[i].committed = 1'b1;
            end
         end
      end
   endtask

   // One clock: check outputs mid-cycle, advance model at the edge, return at next negedge
   task automatic cycle();
      bit acc, exp_ready;
      #1;
      acc       = m_accept(x_issue_req_instr_i);
      exp_ready = (mq.size() < int'(DEPTH)) &&
                  (!acc || (x_issue_req_rs_valid_i[0] && x_issue_req_rs_valid_i[1]));
      chk("issue_ready", 32'(x_issue_ready_o), 32'(exp_ready));
      chk("resp_accept", 32'(x_issue_resp_accept_o), 32'(acc));
      chk("resp_writeback", 32'(x_issue_resp_writeback_o),
          32'(acc && (x_issue_req_instr_i[11:7] != 5'd0)));
      chk("resp_loadstore", 32'(x_issue_resp_loadstore_o), 32'd0);
      chk("result_valid", 32'(x_result_valid_o), 32'(m_rv));
      if (m_rv) begin
         chk("result_id", 32'(x_result_id_o), 32'(m_rid));
         chk("result_data", x_result_data_o, m_rdata);
         chk("result_rd", 32'(x_result_rd_o), 32'(m_rrd));
         chk("result_we", 32'(x_result_we_o), 32'(m_rwe));
      end
      @(posedge clk_i);
      model_step(exp_ready);
      @(negedge clk_i);
   endtask

   task automatic offer(input logic [31:0] ins, input logic [3:0] id, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] rsv);
      x_issue_valid_i        = 1'b1;
      x_issue_req_instr_i    = ins;
      x_issue_req_id_i       = id;
      x_issue_req_rs_i       = {b, a};
      x_issue_req_rs_valid_i = rsv;
   endtask

   task automatic commit(input logic [3:0] id, input logic kill);
      x_commit_valid_i = 1'b1;
      x_commit_id_i    = id;
      x_commit_kill_i  = kill;
   endtask

   task automatic quiet();
      x_issue_valid_i  = 1'b0;
      x_commit_valid_i = 1'b0;
      x_commit_kill_i  = 1'b0;
   endtask

   task automatic do_reset();
      quiet();
      x_issue_req_instr_i    = enc(7'b0001011, 3'd0, 5'd1);
      x_issue_req_rs_valid_i = 3'b011;
      rst_i = 1'b1;
      #1;
      chk("rst_result_valid", 32'(x_result_valid_o), 32'd0);
      chk("rst_result_id", 32'(x_result_id_o), 32'd0);
      chk("rst_result_data", x_result_data_o, 32'd0);
      chk("rst_result_rd", 32'(x_result_rd_o), 32'd0);
      chk("rst_result_we", 32'(x_result_we_o), 32'd0);
      chk("rst_issue_ready", 32'(x_issue_ready_o), 32'd1);
      model_reset();
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic wait_result(input string tag, input int max);
      int n;
      n = 0;
      while (!m_rv && n < max) begin
         cycle();
         n++;
      end
      chk(tag, 32'(x_result_valid_o), 32'd1);
   endtask

   // Commit every undecided entry one per cycle and let the queue empty
   task automatic drain(input int max);
      int  n;
      bit  found;
      n = 0;
      x_result_ready_i = 1'b1;
      while ((mq.size() > 0 || m_rv) && n < max) begin
         quiet();
         found = 1'b0;
         foreach (mq[i]) begin
            if (!found && !mq[i].committed && !mq[i].killed) begin
               commit(mq[i].id, 1'b0);
               found = 1'b1;
            end
         end
         cycle();
         n++;
      end
      quiet();
      cycle();
      chk("drain_valid", 32'(x_result_valid_o), 32'd0);
   endtask

   function automatic logic [3:0] free_id(input logic [3:0] start);
      logic [3:0] c;
      bit         used;
      c = start;
      for (int k = 0; k < 16; k++) begin
         used = 1'b0;
         foreach (mq[j]) if (mq[j].id == c) used = 1'b1;
         if (!used) return c;
         c = c + 4'd1;
      end
      return c;
   endfunction

   initial begin
      logic [3:0]  nid;
      logic [31:0] ins;
      int          n;
      rst_i            = 1'b0;
      x_result_ready_i = 1'b1;
      x_issue_req_id_i = '0;
      x_issue_req_rs_i = '0;
      x_commit_id_i    = '0;
      quiet();
      @(negedge clk_i);
      do_reset();

      // ADD id=3: 5+7 -> rd 9, committed with the issue
      offer(enc(7'b0001011, 3'd0, 5'd9), 4'd3, 32'd5, 32'd7, 3'b011);
      commit(4'd3, 1'b0);
      cycle();
      quiet();
      repeat (4) cycle();
      chk("add_valid", 32'(x_result_valid_o), 32'd1);
      chk("add_id", 32'(x_result_id_o), 32'd3);
      chk("add_data", x_result_data_o, 32'd12);
      chk("add_rd", 32'(x_result_rd_o), 32'd9);
      chk("add_we", 32'(x_result_we_o), 32'd1);
      repeat (3) cycle();

      // Foreign opcode is rejected without queuing
      offer(enc(7'b0110011, 3'd0, 5'd4), 4'd2, 32'd1, 32'd2, 3'b000);
      #1;
      chk("rej_ready", 32'(x_issue_ready_o), 32'd1);
      chk("rej_accept", 32'(x_issue_resp_accept_o), 32'd0);
      chk("rej_writeback", 32'(x_issue_resp_writeback_o), 32'd0);
      cycle();
      quiet();
      repeat (LAT + 4) cycle();

      // Fill the queue with uncommitted entries while results are stalled
      x_result_ready_i = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         offer(enc(7'b0001011, 3'(i), 5'(i + 1)), 4'(i + 4), $urandom(), $urandom(), 3'b011);
         cycle();
      end
      offer(enc(7'b0001011, 3'd0, 5'd2), 4'd8, 32'd1, 32'd1, 3'b011);
      #1;
      chk("full_ready", 32'(x_issue_ready_o), 32'd0);
      cycle();
      quiet();
      commit(4'd4, 1'b1);
      cycle();
      quiet();
      commit(4'd5, 1'b0);
      x_result_ready_i = 1'b1;
      cycle();
      quiet();
      repeat (LAT + 4) cycle();
      drain(60);

      // MUL 0xFFFFFFFF * 2 into x0
      offer(enc(7'b0001011, 3'd2, 5'd0), 4'd11, 32'hFFFF_FFFF, 32'd2, 3'b011);
      commit(4'd11, 1'b0);
      #1;
      chk("mul_writeback", 32'(x_issue_resp_writeback_o), 32'd0);
      cycle();
      quiet();
      wait_result("mul_wait", 20);
      chk("mul_data", x_result_data_o, 32'hFFFF_FFFE);
      chk("mul_we", 32'(x_result_we_o), 32'd0);
      cycle();

      // Result held under back-pressure for 10 cycles, then a single pop
      x_result_ready_i = 1'b0;
      offer(enc(7'b0001011, 3'd3, 5'd17), 4'd12, $urandom(), $urandom(), 3'b111);
      commit(4'd12, 1'b0);
      cycle();
      quiet();
      wait_result("stall_wait", 20);
      repeat (10) cycle();
      x_result_ready_i = 1'b1;
      cycle();
      chk("stall_released", 32'(x_result_valid_o), 32'd0);
      repeat (3) cycle();

      // Randomized traffic
      nid = 4'd0;
      for (int c = 0; c < 500; c++) begin
         quiet();
         if ($urandom_range(0, 2) != 0) begin
            nid = free_id(nid + 4'd1);
            if ($urandom_range(0, 3) != 0)
               ins = enc(7'b0001011, 3'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            else
               ins = $urandom();
            offer(ins, nid, $urandom(), $urandom(),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b011);
            if ($urandom_range(0, 5) == 0) commit(nid, 1'($urandom_range(0, 1)));
         end
         if (!x_commit_valid_i && $urandom_range(0, 1) == 1) begin
            if (mq.size() > 0 && $urandom_range(0, 4) != 0)
               commit(mq[$urandom_range(0, mq.size() - 1)].id, ($urandom_range(0, 3) == 0));
            else
               commit(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         end
         x_result_ready_i = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain(200);

      // Reset while executing with further work queued
      x_result_ready_i = 1'b0;
      offer(enc(7'b0001011, 3'd1, 5'd5), 4'd1, 32'd100, 32'd1, 3'b011);
      commit(4'd1, 1'b0);
      cycle();
      offer(enc(7'b0001011, 3'd0, 5'd6), 4'd2, 32'd3, 32'd4, 3'b011);
      commit(4'd2, 1'b0);
      cycle();
      quiet();
      n = 0;
      while (!m_busy && n < 10) begin
         cycle();
         n++;
      end
      cycle();
      do_reset();
      x_result_ready_i = 1'b1;
      chk("post_rst_valid", 32'(x_result_valid_o), 32'd0);
      repeat (LAT + 5) cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cv32e40p_x_copro_resp.md
# cv32e40p_x_copro_resp

Coprocessor-side responder for the CORE-V-XIF issue, commit and result channels: the accelerator end that accepts or rejects instructions offloaded by the core's X-interface dispatcher. It decodes a small custom-0 ALU instruction set and queues accepted instructions with their operands. It holds each instruction until it is committed, executes it in a fixed-latency unit, and returns the result over the result channel. It sits outside the core and connects directly to the core's X-interface ports.

## Interface
- DEPTH, 4: instruction queue entries; power of two, 2..8.
- LAT, 3: execution latency in cycles; ≥1.
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- x_issue_valid_i  in  1  core offers instruction
- x_issue_ready_o  out  1  responder takes the offer
- x_issue_req_instr_i  in  32  instruction word
- x_issue_req_id_i  in  4  instruction id
- x_issue_req_rs_i  in  2x32  rs1/rs2 operand values
- x_issue_req_rs_valid_i  in  3  operand valid flags; bit 2 unused
- x_issue_resp_accept_o  out  1  instruction is ours
- x_issue_resp_writeback_o  out  1  will write rd
- x_issue_resp_loadstore_o  out  1  tied 0
- x_commit_valid_i  in  1  commit/kill strobe
- x_commit_id_i  in  4  id being committed
- x_commit_kill_i  in  1  1 = discard, 0 = commit
- x_result_valid_o  out  1  result offered
- x_result_ready_i  in  1  core takes result
- x_result_id_o  out  4  id of result
- x_result_data_o  out  32  result value
- x_result_rd_o  out  5  destination register
- x_result_we_o  out  1  write enable; equals rd!=0

## Operation
- Decode is combinational: accept = opcode 7'b0001011 & funct7 == 0 & funct3 in {000 ADD, 001 SUB, 010 MUL (low 32 bits), 011 XOR}. rd = instr[11:7].
- Response outputs are valid in the handshake cycle:
  - x_issue_resp_accept_o = accept.
  - x_issue_resp_writeback_o = accept & rd!=0.
  - x_issue_resp_loadstore_o = 0.
- x_issue_ready_o = ~full & (~accept | (rs_valid[0] & rs_valid[1])).
  - A rejected instruction completes its handshake immediately and nothing is enqueued.
  - full uses the registered count only. When the queue is full, ready stays 0 even if a pop happens in the same cycle.
- Handshake with accept=1: push {id, rd, funct3, rs1, rs2, committed=0, killed=0}.
- Commit strobe: the entry matching the id has its committed or killed bit set, according to x_commit_kill_i.
  - A commit that arrives in the same cycle as the issue of the same id applies to the pushed entry.
  - An unknown id is ignored.
  - A second strobe for an already decided entry is ignored.
- Execution FSM, states IDLE → EXEC → RESULT:
  - IDLE: if the head is killed, pop it (no result) and stay in IDLE. If the head is committed, go to EXEC with cnt = 0.
  - EXEC: cnt increments each cycle. When cnt == LAT-1, register the result and go to RESULT.
  - RESULT: x_result_valid_o = 1. Payload is held stable until x_result_ready_i. On the handshake, pop the head and go to IDLE.
- Arithmetic is modulo 2^32. MUL keeps product[31:0].
- Ids are unique among in-flight entries because DEPTH ≤ 8 < 16.

## Timing
- Reset values:
  - Queue empty, count 0, state IDLE, cnt 0.
  - x_result_valid_o = 0; x_result_id_o, x_result_data_o, x_result_rd_o, x_result_we_o = 0.
  - x_issue_ready_o = 1 for any legal offer with valid operands.
- Reset mid-operation discards all entries and any pending result without a handshake.
- Issue handshake in cycle t with commit in cycle t, queue empty:
  - Entry is visible at t+1; state is IDLE at t+1.
  - EXEC spans t+2 .. t+1+LAT.
  - x_result_valid_o = 1 from t+2+LAT.
- Back-to-back throughput: one result every LAT+2 cycles when x_result_ready_i is held high.
- A killed head is popped one cycle after it becomes head.
- Read and write pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.

## Configuration
- X_COPRO_COMMIT_EN defined: the commit gating described above.
- X_COPRO_COMMIT_EN undefined:
  - Entries are pushed with committed=1.
  - x_commit_* inputs are ignored.
  - Execution begins as soon as the entry reaches the head.
  - This mode is compatible with a dispatcher that commits every instruction unconditionally.

## Test plan
- Reset asserted mid-EXEC with a result pending → next cycle x_result_valid_o = 0, queue empty, x_issue_ready_o = 1.
- ADD id=3, rs1=5, rs2=7, rd=9, committed in the same cycle, LAT=3, x_result_ready_i = 1 → result valid 5 cycles later with id=3, data=12, rd=9, we=1.
- Offer of an opcode other than custom-0 → ready=1, accept=0, writeback=0 in the same cycle; no entry is pushed and no result follows.
- Push DEPTH=4 entries without commit → x_issue_ready_o = 0 on the 5th offer.
  - Kill the head → it pops with no result.
  - Commit the next entry → its result is produced, with ready returning to 1 after the first pop.
- MUL 0xFFFFFFFF × 2 with rd=0 → data 0xFFFFFFFE, we=0, writeback response 0.
- Result stalled with x_result_ready_i = 0 for 10 cycles → valid and payload stable throughout; a single pop on release.
